// File: rtl/mac_stream_accumulator.sv
// -----------------------------------------------------------------------------
// mac_stream_accumulator
//
// Streaming signed multiply-accumulate engine. Takes (activation, weight) pairs
// over a valid/ready stream, adds the full-width products of one vector
// (delimited by io_in_last), and emits one dot-product per vector. The result
// can be saturated or wrapped on overflow.
//
// Pipeline:
//   stage M : registers prod = a*w (2*DATA_W bits), last and first flags
//   stage A : adds prod into the running accumulator; on the last element
//             of a vector it loads the output register instead
//
// Ports:
//   clock          in   rising-edge clock for all state
//   reset          in   asynchronous, active-high; clears all state
//   io_clear       in   synchronous flush of the partially accumulated vector
//   io_in_valid    in   operand pair valid
//   io_in_ready    out  engine can accept an operand pair
//   io_in_a        in   signed activation, DATA_W bits
//   io_in_w        in   signed weight, DATA_W bits
//   io_in_last     in   pair is the final element of the current vector
//   io_out_valid   out  result valid
//   io_out_ready   in   downstream accepts the result
//   io_out_data    out  signed dot-product, ACC_W bits
//   io_out_sat     out  an overflow occurred while accumulating this vector
//   io_out_count   out  element count of this vector (saturates at 2^CNT_W-1)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The source holds valid and its payload steady until that edge. Ready
// may depend combinationally on the registered output state. Valid never
// depends on ready.
// -----------------------------------------------------------------------------
module mac_stream_accumulator #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_clear,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_a,
  input  logic [DATA_W-1:0] io_in_w,
  input  logic              io_in_last,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ACC_W-1:0]  io_out_data,
  output logic              io_out_sat,
  output logic [CNT_W-1:0]  io_out_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Handshake and pipeline control
  // ---------------------------------------------------------------------------
  logic stall;
  logic in_fire;
  logic out_fire;
  logic a_fire;

  // Stage-M registers
  logic              m_valid;
  logic              m_first;
  logic              m_last;
  logic [PROD_W-1:0] m_prod;

  // Vector state
  logic              start;     // next accepted beat opens a new vector
  logic [ACC_W-1:0]  acc;
  logic              sat_flag;
  logic [CNT_W-1:0]  cnt;

  // A pending result that downstream has not taken freezes the whole pipe.
  assign stall       = io_out_valid & ~io_out_ready;
  assign io_in_ready = ~stall & ~io_clear;
  assign in_fire     = io_in_valid & io_in_ready;
  assign out_fire    = io_out_valid & io_out_ready;
  // io_clear drops the stage-M entry, so stage A must not consume it.
  assign a_fire      = m_valid & ~stall & ~io_clear;

  // ---------------------------------------------------------------------------
  // Stage M datapath: sign-extend both operands to the product width so the
  // multiply is done entirely at PROD_W bits. (-2^(DATA_W-1))^2 still fits.
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] w_ext;
  logic [PROD_W-1:0] prod;

  always_comb begin
    a_ext = {{DATA_W{io_in_a[DATA_W-1]}}, io_in_a};
    w_ext = {{DATA_W{io_in_w[DATA_W-1]}}, io_in_w};
    prod  = PROD_W'($signed(a_ext) * $signed(w_ext));
  end

  // ---------------------------------------------------------------------------
  // Stage A datapath. The sum is formed one bit wider than the accumulator.
  // Overflow is detected when the two top bits of that sum disagree.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             overflow;
  logic [ACC_W-1:0] result;
  logic             sat_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    base     = m_first ? '0 : acc;
    sum      = {base[ACC_W-1], base} + {{EXT_W{m_prod[PROD_W-1]}}, m_prod};
    overflow = sum[ACC_W] ^ sum[ACC_W-1];
    result   = sum[ACC_W-1:0];
    if (overflow && (SATURATE != 0)) begin
      // The sign of the wide sum tells which rail was crossed.
      result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    sat_next = (m_first ? 1'b0 : sat_flag) | overflow;
    if (m_first) begin
      cnt_next = CNT_ONE;
    end else if (cnt == CNT_MAX) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid      <= 1'b0;
      m_first      <= 1'b0;
      m_last       <= 1'b0;
      m_prod       <= '0;
      start        <= 1'b1;
      acc          <= '0;
      sat_flag     <= 1'b0;
      cnt          <= '0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      io_out_sat   <= 1'b0;
      io_out_count <= '0;
    end else begin
      // Stage M and the accumulator.
      if (io_clear) begin
        m_valid  <= 1'b0;
        start    <= 1'b1;
        acc      <= '0;
        sat_flag <= 1'b0;
        cnt      <= '0;
      end else if (!stall) begin
        if (in_fire) begin
          m_valid <= 1'b1;
          m_prod  <= prod;
          m_last  <= io_in_last;
          m_first <= start;
          start   <= io_in_last;
        end else begin
          m_valid <= 1'b0;
        end

        if (m_valid) begin
          if (m_last) begin
            // The vector is done: its result goes to the output register.
            acc      <= '0;
            sat_flag <= 1'b0;
            cnt      <= '0;
          end else begin
            acc      <= result;
            sat_flag <= sat_next;
            cnt      <= cnt_next;
          end
        end
      end

      // Output register. A new result loads on the same edge the old one is
      // taken, so vectors stream back to back without a bubble.
      if (a_fire && m_last) begin
        io_out_valid <= 1'b1;
        io_out_data  <= result;
        io_out_sat   <= sat_next;
        io_out_count <= cnt_next;
      end else if (out_fire) begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_stream_accumulator.sv
`timescale 1ns/1ps
module tb_mac_stream_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam int SB_W   = 1 + CNT_W + ACC_W;

  // ---------------------------------------------------------------------------
  // Clock / reset and shared stimulus
  // ---------------------------------------------------------------------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_clear = 1'b0;
  logic              io_in_valid = 1'b0;
  logic              io_in_last = 1'b0;
  logic              io_out_ready = 1'b1;
  logic [DATA_W-1:0] io_in_a = '0;
  logic [DATA_W-1:0] io_in_w = '0;

  always #5 clock = ~clock;

  // Main instance (ACC_W = 24, saturating)
  logic              io_in_ready;
  logic              io_out_valid;
  logic [ACC_W-1:0]  io_out_data;
  logic              io_out_sat;
  logic [CNT_W-1:0]  io_out_count;

  // Narrow-accumulator instances used for the long-vector overflow cases
  logic        s16_in_ready, s16_out_valid, s16_out_sat;
  logic [15:0] s16_out_data;
  logic [7:0]  s16_out_count;
  logic        w16_in_ready, w16_out_valid, w16_out_sat;
  logic [15:0] w16_out_data;
  logic [7:0]  w16_out_count;

  mac_stream_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)) dut (
    .clock(clock), .reset(reset), .io_clear(io_clear),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_w(io_in_w), .io_in_last(io_in_last),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_data(io_out_data), .io_out_sat(io_out_sat), .io_out_count(io_out_count)
  );

  mac_stream_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(1)) dut_s16 (
    .clock(clock), .reset(reset), .io_clear(io_clear),
    .io_in_valid(io_in_valid), .io_in_ready(s16_in_ready),
    .io_in_a(io_in_a), .io_in_w(io_in_w), .io_in_last(io_in_last),
    .io_out_valid(s16_out_valid), .io_out_ready(io_out_ready),
    .io_out_data(s16_out_data), .io_out_sat(s16_out_sat), .io_out_count(s16_out_count)
  );

  mac_stream_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(0)) dut_w16 (
    .clock(clock), .reset(reset), .io_clear(io_clear),
    .io_in_valid(io_in_valid), .io_in_ready(w16_in_ready),
    .io_in_a(io_in_a), .io_in_w(io_in_w), .io_in_last(io_in_last),
    .io_out_valid(w16_out_valid), .io_out_ready(io_out_ready),
    .io_out_data(w16_out_data), .io_out_sat(w16_out_sat), .io_out_count(w16_out_count)
  );

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SB_W-1:0] sb_pack(input bit sat, input int cnt, input int data);
    return {sat, CNT_W'(cnt), ACC_W'(data)};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: every result leaving the main instance is compared with the
  // head of the expected queue.
  // ---------------------------------------------------------------------------
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;

  always @(negedge clock) begin
    #2;
    if (!reset && io_out_valid && io_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data %0d with nothing expected (t=%0t)",
                 $signed(io_out_data), $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data",  $signed(io_out_data), $signed(mon_e[ACC_W-1:0]));
        check("sb_count", io_out_count, mon_e[ACC_W +: CNT_W]);
        check("sb_sat",   io_out_sat, mon_e[SB_W-1]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_beat(input int a, input int w, input bit last);
    int n;
    @(negedge clock);
    io_in_valid = 1'b1;
    io_in_a     = DATA_W'(a);
    io_in_w     = DATA_W'(w);
    io_in_last  = last;
    n = 0;
    while (1) begin
      @(posedge clock);
      if (io_in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!io_out_valid && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("wait_out_valid", io_out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic run_long(input int a, input int w, input int exp_main,
                          input int exp_s16, input int exp_w16);
    exp_q.push_back(sb_pack(1'b1, 255, exp_main));
    for (int i = 0; i < 600; i++) send_beat(a, w, i == 599);
    idle();
    wait_out_valid();
    check("s16_data",  $signed(s16_out_data), exp_s16);
    check("s16_sat",   s16_out_sat, 1);
    check("s16_count", s16_out_count, 255);
    check("w16_data",  $signed(w16_out_data), exp_w16);
    check("w16_sat",   w16_out_sat, 1);
    check("w16_count", w16_out_count, 255);
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int a;
    int w;
    bit last;
    int exp_data;
    int exp_count;
    bit exp_sat;
  } vec_t;

  localparam int N_VEC = 14;
  vec_t tbl[N_VEC];

  initial begin
    tbl[0]  = '{a: 1,    w: 5,    last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[1]  = '{a: -2,   w: 5,    last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[2]  = '{a: 3,    w: -1,   last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[3]  = '{a: 127,  w: -128, last: 1, exp_data: -16264, exp_count: 4, exp_sat: 0};
    tbl[4]  = '{a: -128, w: -128, last: 1, exp_data: 16384,  exp_count: 1, exp_sat: 0};
    tbl[5]  = '{a: 10,   w: -3,   last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[6]  = '{a: -20,  w: 4,    last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[7]  = '{a: 7,    w: 7,    last: 1, exp_data: -61,    exp_count: 3, exp_sat: 0};
    tbl[8]  = '{a: 0,    w: 55,   last: 1, exp_data: 0,      exp_count: 1, exp_sat: 0};
    tbl[9]  = '{a: 127,  w: 127,  last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[10] = '{a: 127,  w: -128, last: 1, exp_data: -127,   exp_count: 2, exp_sat: 0};
    tbl[11] = '{a: -128, w: -128, last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[12] = '{a: -128, w: -128, last: 0, exp_data: 0,      exp_count: 0, exp_sat: 0};
    tbl[13] = '{a: -128, w: -128, last: 1, exp_data: 49152,  exp_count: 3, exp_sat: 0};

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out_data",  $signed(io_out_data), 0);
    check("rst_out_sat",   io_out_sat, 0);
    check("rst_out_count", io_out_count, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", io_in_ready, 1);

    // 4-beat vector with latency and single-cycle valid
    exp_q.push_back(sb_pack(1'b0, 4, -16264));
    send_beat(1, 5, 0);
    send_beat(-2, 5, 0);
    send_beat(3, -1, 0);
    send_beat(127, -128, 1);
    idle();
    #1;
    check("lat_not_yet", io_out_valid, 0);
    @(negedge clock);
    #1;
    check("lat_valid", io_out_valid, 1);
    check("lat_data",  $signed(io_out_data), -16264);
    @(negedge clock);
    #1;
    check("one_cycle_valid", io_out_valid, 0);
    drain();

    // Table: streamed back to back with out_ready high
    for (int i = 0; i < N_VEC; i++) begin
      if (tbl[i].last)
        exp_q.push_back(sb_pack(tbl[i].exp_sat, tbl[i].exp_count, tbl[i].exp_data));
      send_beat(tbl[i].a, tbl[i].w, tbl[i].last);
    end
    idle();
    drain();

    // Back-to-back vectors with a 5-cycle downstream stall
    @(negedge clock);
    io_out_ready = 1'b0;
    exp_q.push_back(sb_pack(1'b0, 2, -9));
    exp_q.push_back(sb_pack(1'b0, 2, -2200));
    fork
      begin
        send_beat(2, 6, 0);
        send_beat(-3, 7, 1);
        send_beat(-50, 40, 0);
        send_beat(25, -8, 1);
        idle();
      end
      begin
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", io_in_ready, 0);
          check("stall_valid",    io_out_valid, 1);
          check("stall_data",     $signed(io_out_data), -9);
          @(negedge clock);
          #1;
        end
        io_out_ready = 1'b1;
      end
    join
    drain();

    // io_clear while a result is pending: the result must survive
    @(negedge clock);
    io_out_ready = 1'b0;
    exp_q.push_back(sb_pack(1'b0, 1, 25));
    send_beat(5, 5, 1);
    idle();
    wait_out_valid();
    @(negedge clock);
    io_clear = 1'b1;
    #1;
    check("clear_in_ready", io_in_ready, 0);
    @(negedge clock);
    io_clear = 1'b0;
    #1;
    check("clear_keep_valid", io_out_valid, 1);
    check("clear_keep_data",  $signed(io_out_data), 25);
    io_out_ready = 1'b1;
    drain();

    // io_clear after 3 beats drops the partial vector
    send_beat(7, 7, 0);
    send_beat(8, -8, 0);
    send_beat(9, 9, 0);
    @(negedge clock);
    io_in_valid = 1'b0;
    io_clear    = 1'b1;
    #1;
    check("clear2_in_ready", io_in_ready, 0);
    @(negedge clock);
    io_clear = 1'b0;
    exp_q.push_back(sb_pack(1'b0, 2, 20));
    send_beat(2, 4, 0);
    send_beat(3, 4, 1);
    idle();
    drain();

    // Long vectors: overflow, saturation, wrap, count saturation
    // 600*16129 = 9677400 ; low 16 bits = 0xAA58 = -21928
    run_long(127, 127, 8388607, 32767, -21928);
    // 600*-16256 = -9753600 ; low 16 bits = 0x2C00 = 11264
    run_long(-128, 127, -8388608, -32768, 11264);

    // Asynchronous reset mid-vector with a pending result
    @(negedge clock);
    io_out_ready = 1'b0;
    send_beat(4, 4, 0);
    send_beat(4, 4, 1);
    send_beat(6, 6, 0);
    idle();
    #1;
    check("pre_rst_valid", io_out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", io_out_valid, 0);
    check("async_rst_data",  $signed(io_out_data), 0);
    check("async_rst_sat",   io_out_sat, 0);
    check("async_rst_count", io_out_count, 0);
    check("async_rst_ready", io_in_ready, 1);
    @(negedge clock);
    reset        = 1'b0;
    io_out_ready = 1'b1;
    exp_q.push_back(sb_pack(1'b0, 2, -3));
    send_beat(3, 3, 0);
    send_beat(-4, 3, 1);
    idle();
    drain();

    repeat (3) @(negedge clock);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
